prm_edge_mask_engine: RTL and testbench



---
 rtl/prm_edge_mask_engine.sv | 173 +++++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_engine.sv
// rtl/prm_edge_mask_engine.sv - PRM edge mask engine: sequential cube-table scan producing per-edge collision masks
//
// Purpose: holds a table of product terms (cubes). Each cube has a care mask,
// a required polarity and a target edge channel. A query word is compared
// against one active cube per cycle. Every matching cube sets its edge bit in
// the result mask. The scan can stop early once all edges requested in q_en
// are already masked.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_edge/        cube table write (honoured only in IDLE)
//   cfg_care/cfg_val
//   cfg_cnt_we/cfg_cnt               active cube count load, saturated to DEPTH
//   cfg_err                          one-cycle pulse after a dropped config write
//   q_valid/q_ready/q_data/q_en      query handshake plus early-exit edge set
//   res_valid/res_ready/res_mask     result handshake
//   busy                             high while scanning or holding a result
module prm_edge_mask_engine #(
  parameter int IN_W      = 15,
  parameter int NUM_EDGES = 8,
  parameter int DEPTH     = 32,
  parameter int EW        = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [EW-1:0]        cfg_edge,
  input  logic [IN_W-1:0]      cfg_care,
  input  logic [IN_W-1:0]      cfg_val,
  input  logic                 cfg_cnt_we,
  input  logic [AW:0]          cfg_cnt,
  output logic                 cfg_err,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [IN_W-1:0]      q_data,
  input  logic [NUM_EDGES-1:0] q_en,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_EDGES-1:0] res_mask,
  output logic                 busy
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AW:0]          idx_q, idx_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [NUM_EDGES-1:0] acc_q, acc_d;
  logic [NUM_EDGES-1:0] qen_q, qen_d;
  logic [IN_W-1:0]      qdata_q, qdata_d;
  logic                 cfg_err_q, cfg_err_d;

  // Cube table; contents are inert until cnt_q covers them, so no reset.
  logic [IN_W-1:0] care_mem [DEPTH];
  logic [IN_W-1:0] val_mem  [DEPTH];
  logic [EW-1:0]   edge_mem [DEPTH];

  logic                 is_idle;
  logic                 table_we;
  logic [AW:0]          cnt_sat;
  logic [IN_W-1:0]      cur_care;
  logic [IN_W-1:0]      cur_val;
  logic [EW-1:0]        cur_edge;
  logic                 cube_hit;
  logic [NUM_EDGES-1:0] acc_scan;
  logic                 last_cube;
  logic                 early_exit;

  assign is_idle  = (state_q == S_IDLE);
  assign table_we = cfg_we & is_idle;
  assign cnt_sat  = (cfg_cnt > DEPTH_C) ? DEPTH_C : cfg_cnt;

  always_ff @(posedge clk) begin
    if (table_we) begin
      care_mem[cfg_addr] <= cfg_care;
      val_mem[cfg_addr]  <= cfg_val;
      edge_mem[cfg_addr] <= cfg_edge;
    end
  end

  // Only read while scanning, where idx_q < cnt_q <= DEPTH holds.
  assign cur_care = care_mem[idx_q[AW-1:0]];
  assign cur_val  = val_mem[idx_q[AW-1:0]];
  assign cur_edge = edge_mem[idx_q[AW-1:0]];

  // A cleared care bit removes that literal; all-zero care always matches.
  assign cube_hit = (((qdata_q ^ cur_val) & cur_care) == '0);

  // Edge ids outside the channel range shift out and contribute nothing.
  assign acc_scan = acc_q | ({{(NUM_EDGES-1){1'b0}}, cube_hit} << cur_edge);

  assign last_cube  = ((idx_q + 1'b1) >= cnt_q);
  assign early_exit = (qen_q != '0) && ((acc_scan & qen_q) == qen_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qen_d     = qen_q;
    qdata_d   = qdata_q;
    cfg_err_d = 1'b0;

    if (is_idle) begin
      if (cfg_cnt_we) begin
        cnt_d = cnt_sat;
      end
    end else if (cfg_we || cfg_cnt_we) begin
      cfg_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (q_valid) begin
          qdata_d = q_data;
          qen_d   = q_en;
          acc_d   = '0;
          idx_d   = '0;
          // A count loaded in the same cycle is the one the query runs with.
          state_d = (cnt_d == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        acc_d = acc_scan;
        idx_d = idx_q + 1'b1;
        if (last_cube || early_exit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      qen_q     <= '0;
      qdata_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      qen_q     <= qen_d;
      qdata_q   <= qdata_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign q_ready   = is_idle;
  assign res_valid = (state_q == S_DONE);
  assign res_mask  = acc_q;
  assign busy      = ~is_idle;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb/tb_prm_edge_mask_engine.sv - self-checking bench for prm_edge_mask_engine
module tb_prm_edge_mask_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [2:0]  cfg_edge;
  logic [14:0] cfg_care;
  logic [14:0] cfg_val;
  logic        cfg_cnt_we;
  logic [5:0]  cfg_cnt;
  logic        cfg_err;
  logic        q_valid;
  logic        q_ready;
  logic [14:0] q_data;
  logic [7:0]  q_en;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_mask;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference table as seen by software.
  logic [14:0] m_care [32];
  logic [14:0] m_val  [32];
  int          m_edge [32];
  int          m_cnt;

  prm_edge_mask_engine #(.IN_W(15), .NUM_EDGES(8), .DEPTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_edge   (cfg_edge),
    .cfg_care   (cfg_care),
    .cfg_val    (cfg_val),
    .cfg_cnt_we (cfg_cnt_we),
    .cfg_cnt    (cfg_cnt),
    .cfg_err    (cfg_err),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_data     (q_data),
    .q_en       (q_en),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_mask   (res_mask),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected mask and accept-to-result latency straight from the edge rules.
  function automatic void model(input logic [14:0] d, input logic [7:0] en,
                                output logic [7:0] mask, output int lat);
    mask = 8'h00;
    lat  = m_cnt + 1;
    for (int k = 0; k < m_cnt; k++) begin
      if (((d ^ m_val[k]) & m_care[k]) == 15'h0) mask[m_edge[k]] = 1'b1;
      if (en != 8'h00 && (mask & en) == en) begin
        lat = k + 2;
        break;
      end
    end
  endfunction

  task automatic write_cube(input int a, input int e, input logic [14:0] c, input logic [14:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_edge = 3'(e); cfg_care = c; cfg_val = v;
    @(negedge clk);
    cfg_we = 1'b0;
    m_care[a] = c; m_val[a] = v; m_edge[a] = e;
  endtask

  task automatic write_cnt(input int n);
    @(negedge clk);
    cfg_cnt_we = 1'b1; cfg_cnt = 6'(n);
    @(negedge clk);
    cfg_cnt_we = 1'b0;
    m_cnt = (n > 32) ? 32 : n;
  endtask

  // hold: cycles res_ready stays low once the result is up.
  // inject: scan cycle at which a config write is attempted (-1 for none).
  // co: also write cube 0 from the model in the accept cycle.
  task automatic run_query(input logic [14:0] d, input logic [7:0] en,
                           input int hold, input int inject, input bit co);
    logic [7:0] em;
    int el;
    int lat;
    model(d, en, em, el);
    @(negedge clk);
    q_valid = 1'b1; q_data = d; q_en = en;
    if (co) begin
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_edge = 3'(m_edge[0]);
      cfg_care = m_care[0]; cfg_val = m_val[0];
    end
    chk("q_ready_idle", q_ready, 1);
    @(negedge clk);
    q_valid = 1'b0; cfg_we = 1'b0;
    lat = 1;
    while (!res_valid && lat < 200) begin
      if (lat == inject) begin
        chk("busy_scan", busy, 1);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_edge = 3'd7; cfg_care = 15'h0; cfg_val = 15'h0;
        cfg_cnt_we = 1'b1; cfg_cnt = 6'd0;
      end
      if (lat == inject + 1) begin
        cfg_we = 1'b0; cfg_cnt_we = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
      end
      if (lat == inject + 2) chk("cfg_err_clear", cfg_err, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    chk("res_mask", res_mask, em);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_mask", res_mask, em);
      chk("hold_q_ready", q_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_dropped", res_valid, 0);
    chk("q_ready_back", q_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [14:0] d;
    logic [7:0]  en;
    int          seen;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_edge = '0; cfg_care = '0; cfg_val = '0;
    cfg_cnt_we = 1'b0; cfg_cnt = '0; q_valid = 1'b0; q_data = '0; q_en = '0; res_ready = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 32; k++) begin m_care[k] = '0; m_val[k] = '0; m_edge[k] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_q_ready", q_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_mask", res_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Single exact cube.
    write_cube(0, 3, 15'h7FFF, 15'h1234);
    write_cnt(1);
    run_query(15'h1234, 8'h00, 0, -1, 1'b0);
    run_query(15'h1235, 8'h00, 0, -1, 1'b0);

    // Empty table.
    write_cnt(0);
    run_query(15'h0000, 8'h00, 0, -1, 1'b0);

    // All-don't-care cubes, early exit vs full scan.
    for (int k = 0; k < 32; k++) write_cube(k, k % 8, 15'h0000, 15'(k * 37));
    write_cnt(32);
    run_query(15'h5A5A, 8'h01, 0, -1, 1'b0);
    run_query(15'h5A5A, 8'h00, 0, -1, 1'b0);

    // Result held under backpressure.
    run_query(15'h0001, 8'h00, 5, -1, 1'b0);

    // Distinct exact cubes; config writes during the scan are dropped.
    for (int k = 0; k < 32; k++) write_cube(k, k % 8, 15'h7FFF, 15'(k));
    run_query(15'h0005, 8'h00, 0, 3, 1'b0);
    run_query(15'h0005, 8'h00, 0, -1, 1'b0);

    // Reset during scan cycle 3.
    @(negedge clk);
    q_valid = 1'b1; q_data = 15'h0005; q_en = 8'h00;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res_mask", res_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_q_ready", q_ready, 1);
    run_query(15'h0005, 8'h00, 0, -1, 1'b0);

    // Cube write and query accepted in the same cycle.
    write_cube(0, 3, 15'h7FFF, 15'h1234);
    write_cnt(1);
    m_edge[0] = 6; m_care[0] = 15'h0000; m_val[0] = 15'h0000;
    run_query(15'h1234, 8'h00, 0, -1, 1'b1);

    // Randomised tables and queries, including counts above DEPTH.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 32; k++)
        write_cube(k, int'($urandom_range(0, 7)), 15'($urandom & $urandom & $urandom), 15'($urandom));
      write_cnt(int'($urandom_range(0, 40)));
      for (int n = 0; n < 10; n++) begin
        d  = m_val[$urandom_range(0, 31)] ^ 15'($urandom & $urandom & $urandom);
        en = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
        run_query(d, en, int'($urandom_range(0, 2)), -1, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
